// File: rtl/sdram_chk_pkg.sv
// Shared definitions for the SDRAM/Wishbone protocol checker.
// Latency: n/a (types, constants and a decode helper only).
// Backpressure: n/a.
package sdram_chk_pkg;

    // SDRAM command encoding on {ras_n, cas_n, we_n}
    typedef enum logic [2:0] {
        CMD_MRS   = 3'b000,
        CMD_AREF  = 3'b001,
        CMD_PRE   = 3'b010,
        CMD_ACT   = 3'b011,
        CMD_WRITE = 3'b100,
        CMD_READ  = 3'b101,
        CMD_BST   = 3'b110,
        CMD_NOP   = 3'b111
    } sdram_cmd_e;

    // Power-up initialisation tracking states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PWR_NOP   = 3'd1,
        ST_WAIT_PRE  = 3'd2,
        ST_WAIT_AREF = 3'd3,
        ST_WAIT_MRS  = 3'd4,
        ST_RUN       = 3'd5
    } init_state_e;

    // Bit positions inside err_flags
    localparam int ERR_INIT     = 0;
    localparam int ERR_CAS      = 1;
    localparam int ERR_ACT_OPEN = 2;
    localparam int ERR_CLOSED   = 3;
    localparam int ERR_RDATA    = 4;
    localparam int ERR_CYCSTB   = 5;
    localparam int ERR_ACK_TO   = 6;
    localparam int ERR_ACK_SPUR = 7;

    function automatic sdram_cmd_e decode_cmd(input logic ras_n, input logic cas_n,
                                              input logic we_n);
        return sdram_cmd_e'({ras_n, cas_n, we_n});
    endfunction

endpackage

// File: rtl/wb_handshake_checker.sv
// Wishbone handshake monitor: stb/cyc mismatch, ack timeout, spurious ack.
// Latency: error strobes are combinational in the offending cycle.
// Backpressure: none, passive observer of the bus.
module wb_handshake_checker #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic wb_cyc_i,
    input  logic wb_stb_i,
    input  logic wb_ack_i,
    output logic err_cycstb_o,
    output logic err_ack_to_o,
    output logic err_ack_spur_o
);

    localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(ACK_TIMEOUT);

    logic            req;
    logic [TO_W-1:0] tmr_q;
    logic [TO_W-1:0] tmr_d;

    assign req            = wb_stb_i & wb_cyc_i;
    assign err_cycstb_o   = wb_stb_i ^ wb_cyc_i;
    assign err_ack_spur_o = wb_ack_i & ~req;

    // Count cycles of an unacknowledged request; the timer parks at TO_MAX
    // so one stalled request reports its timeout exactly once.
    always_comb begin
        tmr_d        = tmr_q;
        err_ack_to_o = 1'b0;
        if (!req || wb_ack_i) begin
            tmr_d = '0;
        end else if (tmr_q != TO_MAX) begin
            tmr_d = tmr_q + TO_W'(1);
            if (tmr_q == TO_LAST) begin
                err_ack_to_o = 1'b1;
            end
        end
    end

    // Timer register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end

endmodule

// File: rtl/sdram_protocol_checker.sv
// SDRAM init/bank/read-latency and Wishbone handshake protocol checker.
// Latency: errors detected in cycle T show in err_flags/err_pulse/err_count after the T edge.
// Backpressure: none, passive monitor; all inputs are observed every cycle.
module sdram_protocol_checker
    import sdram_chk_pkg::*;
#(
    parameter int INIT_NOP_CYCLES = 10000,
    parameter int NUM_AREF        = 2,
    parameter int NUM_BANKS       = 4,
    parameter int ACK_TIMEOUT     = 16,
    parameter int CNT_W           = 16
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_i,
    input  logic                         sdram_en,
    input  logic                         sdram_ras_n,
    input  logic                         sdram_cas_n,
    input  logic                         sdram_we_n,
    input  logic [$clog2(NUM_BANKS)-1:0] sdram_ba,
    input  logic                         sdram_a10,
    input  logic                         sdram_dq_valid,
    input  logic [2:0]                   cfg_cas,
    input  logic                         wb_cyc_i,
    input  logic                         wb_stb_i,
    input  logic                         wb_ack_o,
    input  logic                         err_clr,
    output logic                         init_done,
    output logic [7:0]                   err_flags,
    output logic                         err_pulse,
    output logic [CNT_W-1:0]             err_count
);

    localparam int NOP_W  = $clog2(INIT_NOP_CYCLES + 1);
    localparam int AREF_W = $clog2(NUM_AREF + 1);
    localparam logic [NOP_W-1:0]  NOP_LAST  = NOP_W'(INIT_NOP_CYCLES - 1);
    localparam logic [AREF_W-1:0] AREF_LAST = AREF_W'(NUM_AREF - 1);

    sdram_cmd_e           cmd;
    init_state_e          state_q, state_d;
    logic                 en_q;
    logic                 en_rise;
    logic [NOP_W-1:0]     nop_cnt_q, nop_cnt_d;
    logic [AREF_W-1:0]    aref_cnt_q, aref_cnt_d;
    logic                 init_err;
    logic                 run;
    logic [NUM_BANKS-1:0] bank_open_q, bank_open_d;
    logic [3:0]           rd_sr_q, rd_sr_d;
    logic                 cas_flagged_q, cas_flagged_d;
    logic                 ev_cas, ev_act_open, ev_closed, ev_rdata;
    logic                 wb_cycstb, wb_ack_to, wb_ack_spur;
    logic [7:0]           err_ev;
    logic                 any_ev;
    logic [7:0]           err_flags_q, err_flags_d;
    logic                 err_pulse_q;
    logic [CNT_W-1:0]     err_count_q, err_count_d;

    assign cmd     = decode_cmd(sdram_ras_n, sdram_cas_n, sdram_we_n);
    assign en_rise = sdram_en & ~en_q;
    assign run     = (state_q == ST_RUN);

    // Init sequence tracking: any illegal command aborts back to IDLE,
    // and only a fresh sdram_en rise restarts the sequence.
    always_comb begin
        state_d    = state_q;
        nop_cnt_d  = nop_cnt_q;
        aref_cnt_d = aref_cnt_q;
        init_err   = 1'b0;
        if (!sdram_en) begin
            state_d    = ST_IDLE;
            nop_cnt_d  = '0;
            aref_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (en_rise) begin
                        state_d   = ST_PWR_NOP;
                        nop_cnt_d = '0;
                    end
                end
                ST_PWR_NOP: begin
                    if (cmd == CMD_NOP) begin
                        if (nop_cnt_q == NOP_LAST) begin
                            state_d = ST_WAIT_PRE;
                        end else begin
                            nop_cnt_d = nop_cnt_q + NOP_W'(1);
                        end
                    end else begin
                        init_err = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
                ST_WAIT_PRE: begin
                    if (cmd == CMD_PRE && sdram_a10) begin
                        state_d    = ST_WAIT_AREF;
                        aref_cnt_d = '0;
                    end else if (cmd != CMD_NOP) begin
                        init_err = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
                ST_WAIT_AREF: begin
                    if (cmd == CMD_AREF) begin
                        if (aref_cnt_q == AREF_LAST) begin
                            state_d = ST_WAIT_MRS;
                        end else begin
                            aref_cnt_d = aref_cnt_q + AREF_W'(1);
                        end
                    end else if (cmd != CMD_NOP) begin
                        init_err = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
                ST_WAIT_MRS: begin
                    if (cmd == CMD_MRS) begin
                        state_d = ST_RUN;
                    end else if (cmd != CMD_NOP) begin
                        init_err = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
                ST_RUN:  state_d = ST_RUN;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Bank-open tracking, CAS sanity and read-data latency checks (RUN only).
    // rd_sr bit k means "a read expects data k+1 cycles from now"; bit 0 is due this cycle.
    always_comb begin
        bank_open_d   = bank_open_q;
        rd_sr_d       = {1'b0, rd_sr_q[3:1]};
        cas_flagged_d = cas_flagged_q;
        ev_cas        = 1'b0;
        ev_act_open   = 1'b0;
        ev_closed     = 1'b0;
        ev_rdata      = 1'b0;
        if (!run) begin
            bank_open_d   = '0;
            rd_sr_d       = '0;
            cas_flagged_d = 1'b0;
        end else begin
            ev_rdata = rd_sr_q[0] & ~sdram_dq_valid;
            if (!cas_flagged_q && cfg_cas != 3'd2 && cfg_cas != 3'd3) begin
                ev_cas        = 1'b1;
                cas_flagged_d = 1'b1;
            end
            case (cmd)
                CMD_ACT: begin
                    ev_act_open           = bank_open_q[sdram_ba];
                    bank_open_d[sdram_ba] = 1'b1;
                end
                CMD_PRE: begin
                    if (sdram_a10) begin
                        bank_open_d = '0;
                    end else begin
                        bank_open_d[sdram_ba] = 1'b0;
                    end
                end
                CMD_READ: begin
                    ev_closed = ~bank_open_q[sdram_ba];
                    case (cfg_cas)
                        3'd1:    rd_sr_d[0] = 1'b1;
                        3'd2:    rd_sr_d[1] = 1'b1;
                        3'd3:    rd_sr_d[2] = 1'b1;
                        3'd4:    rd_sr_d[3] = 1'b1;
                        default: rd_sr_d[0] = rd_sr_q[1];
                    endcase
                end
                CMD_WRITE: ev_closed = ~bank_open_q[sdram_ba];
                CMD_AREF:  ev_closed = |bank_open_q;
                default:   ev_closed = 1'b0;
            endcase
        end
    end

    wb_handshake_checker #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_wb_chk (
        .clk_i          (wb_clk_i),
        .rst_i          (wb_rst_i),
        .wb_cyc_i       (wb_cyc_i),
        .wb_stb_i       (wb_stb_i),
        .wb_ack_i       (wb_ack_o),
        .err_cycstb_o   (wb_cycstb),
        .err_ack_to_o   (wb_ack_to),
        .err_ack_spur_o (wb_ack_spur)
    );

    // Collect this cycle's error events and compute sticky flags / saturating count.
    always_comb begin
        err_ev               = '0;
        err_ev[ERR_INIT]     = init_err;
        err_ev[ERR_CAS]      = ev_cas;
        err_ev[ERR_ACT_OPEN] = ev_act_open;
        err_ev[ERR_CLOSED]   = ev_closed;
        err_ev[ERR_RDATA]    = ev_rdata;
        err_ev[ERR_CYCSTB]   = wb_cycstb;
        err_ev[ERR_ACK_TO]   = wb_ack_to;
        err_ev[ERR_ACK_SPUR] = wb_ack_spur;
        any_ev               = |err_ev;
        err_flags_d          = (err_clr ? 8'h00 : err_flags_q) | err_ev;
        err_count_d          = err_count_q;
        if (err_clr) begin
            err_count_d = any_ev ? CNT_W'(1) : '0;
        end else if (any_ev && err_count_q != {CNT_W{1'b1}}) begin
            err_count_d = err_count_q + CNT_W'(1);
        end
    end

    // State registers. en_q resets high so an enable already asserted
    // across reset is not mistaken for a new rising edge.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q       <= ST_IDLE;
            en_q          <= 1'b1;
            nop_cnt_q     <= '0;
            aref_cnt_q    <= '0;
            bank_open_q   <= '0;
            rd_sr_q       <= '0;
            cas_flagged_q <= 1'b0;
            err_flags_q   <= '0;
            err_pulse_q   <= 1'b0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            en_q          <= sdram_en;
            nop_cnt_q     <= nop_cnt_d;
            aref_cnt_q    <= aref_cnt_d;
            bank_open_q   <= bank_open_d;
            rd_sr_q       <= rd_sr_d;
            cas_flagged_q <= cas_flagged_d;
            err_flags_q   <= err_flags_d;
            err_pulse_q   <= any_ev;
            err_count_q   <= err_count_d;
        end
    end

    assign init_done = run;
    assign err_flags = err_flags_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_sdram_protocol_checker.sv
// Directed self-checking bench for sdram_protocol_checker.
// Inputs change 1ns after each rising edge; outputs are sampled at that point.
// Small parameters (8 init NOPs, ack timeout 4, 2-bit error counter) keep runs short.
module tb_sdram_protocol_checker;

    localparam logic [2:0] C_NOP  = 3'b111;
    localparam logic [2:0] C_ACT  = 3'b011;
    localparam logic [2:0] C_READ = 3'b101;
    localparam logic [2:0] C_PRE  = 3'b010;
    localparam logic [2:0] C_AREF = 3'b001;
    localparam logic [2:0] C_MRS  = 3'b000;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       ras_n, cas_n, we_n;
    logic [1:0] ba;
    logic       a10;
    logic       dq_valid;
    logic [2:0] cfg_cas;
    logic       cyc, stb, ack;
    logic       clr;
    logic       init_done;
    logic [7:0] err_flags;
    logic       err_pulse;
    logic [1:0] err_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sdram_protocol_checker #(
        .INIT_NOP_CYCLES (8),
        .NUM_AREF        (2),
        .NUM_BANKS       (4),
        .ACK_TIMEOUT     (4),
        .CNT_W           (2)
    ) dut (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst),
        .sdram_en       (en),
        .sdram_ras_n    (ras_n),
        .sdram_cas_n    (cas_n),
        .sdram_we_n     (we_n),
        .sdram_ba       (ba),
        .sdram_a10      (a10),
        .sdram_dq_valid (dq_valid),
        .cfg_cas        (cfg_cas),
        .wb_cyc_i       (cyc),
        .wb_stb_i       (stb),
        .wb_ack_o       (ack),
        .err_clr        (clr),
        .init_done      (init_done),
        .err_flags      (err_flags),
        .err_pulse      (err_pulse),
        .err_count      (err_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] c, input logic [1:0] b, input logic a);
        {ras_n, cas_n, we_n} = c;
        ba  = b;
        a10 = a;
        tick();
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) issue(C_NOP, 2'd0, 1'b0);
    endtask

    task automatic clear_errs();
        clr = 1'b1;
        nops(1);
        clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; {ras_n, cas_n, we_n} = C_NOP; ba = 2'd0; a10 = 1'b0;
        dq_valid = 1'b0; cfg_cas = 3'd3; cyc = 1'b0; stb = 1'b0; ack = 1'b0; clr = 1'b0;
        tick(); tick();
        check_eq("rst_init_done", init_done, 0);
        check_eq("rst_flags", err_flags, 0);
        check_eq("rst_pulse", err_pulse, 0);
        check_eq("rst_count", err_count, 0);
        rst = 1'b0;
        tick();

        // Legal init sequence
        en = 1'b1;
        nops(1);
        nops(8);
        issue(C_PRE, 2'd0, 1'b1);
        check_eq("init_after_pre", init_done, 0);
        nops(1);
        issue(C_AREF, 2'd0, 1'b0);
        issue(C_AREF, 2'd0, 1'b0);
        check_eq("init_before_mrs", init_done, 0);
        issue(C_MRS, 2'd0, 1'b0);
        check_eq("init_done", init_done, 1);
        check_eq("init_flags", err_flags, 0);
        check_eq("init_count", err_count, 0);

        // Read latency: data one cycle early -> miss
        issue(C_ACT, 2'd0, 1'b0);
        issue(C_READ, 2'd0, 1'b0);
        nops(1);
        dq_valid = 1'b1; nops(1); dq_valid = 1'b0;
        check_eq("rd_early_t2", err_flags, 0);
        nops(1);
        check_eq("rd_early_flag", err_flags, 8'h10);
        check_eq("rd_early_pulse", err_pulse, 1);
        check_eq("rd_early_count", err_count, 1);
        clear_errs();
        check_eq("clr_flags", err_flags, 0);
        check_eq("clr_count", err_count, 0);

        // Read latency: data on time -> ok
        issue(C_READ, 2'd0, 1'b0);
        nops(2);
        dq_valid = 1'b1; nops(1); dq_valid = 1'b0;
        check_eq("rd_ok_flags", err_flags, 0);
        check_eq("rd_ok_pulse", err_pulse, 0);

        // Back-to-back reads, only the first gets data
        issue(C_READ, 2'd0, 1'b0);
        issue(C_READ, 2'd0, 1'b0);
        nops(1);
        dq_valid = 1'b1; nops(1); dq_valid = 1'b0;
        check_eq("b2b_first_ok", err_flags, 0);
        nops(1);
        check_eq("b2b_second_miss", err_flags, 8'h10);
        clear_errs();

        // Illegal CAS latency flagged once
        cfg_cas = 3'd5;
        nops(1);
        check_eq("cas_flag", err_flags, 8'h02);
        check_eq("cas_pulse", err_pulse, 1);
        nops(1);
        check_eq("cas_once_pulse", err_pulse, 0);
        check_eq("cas_once_count", err_count, 1);
        cfg_cas = 3'd3;
        clear_errs();
        issue(C_PRE, 2'd0, 1'b1);

        // Bank tracking
        issue(C_ACT, 2'd1, 1'b0);
        check_eq("act_first", err_flags, 0);
        issue(C_ACT, 2'd1, 1'b0);
        check_eq("act_open", err_flags, 8'h04);
        issue(C_PRE, 2'd0, 1'b1);
        dq_valid = 1'b1;
        issue(C_READ, 2'd1, 1'b0);
        check_eq("rd_closed", err_flags, 8'h0C);
        check_eq("bank_count", err_count, 2);
        nops(3);
        dq_valid = 1'b0;
        check_eq("bank_count_hold", err_count, 2);
        clear_errs();

        // Early command during power-up NOPs
        en = 1'b0; nops(1);
        check_eq("en_fall_idle", init_done, 0);
        en = 1'b1; nops(1);
        nops(5);
        issue(C_ACT, 2'd0, 1'b0);
        check_eq("early_flag", err_flags, 8'h01);
        check_eq("early_pulse", err_pulse, 1);
        check_eq("early_count", err_count, 1);
        nops(1);
        check_eq("early_pulse_end", err_pulse, 0);
        issue(C_PRE, 2'd0, 1'b1);
        nops(1);
        issue(C_AREF, 2'd0, 1'b0);
        issue(C_AREF, 2'd0, 1'b0);
        issue(C_MRS, 2'd0, 1'b0);
        check_eq("idle_no_init", init_done, 0);
        check_eq("idle_no_err", err_count, 1);
        clear_errs();

        // Wishbone ack timeout then spurious ack
        stb = 1'b1; cyc = 1'b1;
        tick(); tick(); tick();
        check_eq("to_3cyc", err_flags, 0);
        tick();
        check_eq("to_flag", err_flags, 8'h40);
        check_eq("to_pulse", err_pulse, 1);
        tick();
        check_eq("to_once", err_pulse, 0);
        stb = 1'b0; cyc = 1'b0; ack = 1'b1;
        tick();
        check_eq("spur_flags", err_flags, 8'hC0);
        check_eq("spur_count", err_count, 2);
        ack = 1'b0; tick();
        ack = 1'b1; clr = 1'b1;
        tick();
        check_eq("clr_spur_flags", err_flags, 8'h80);
        check_eq("clr_spur_count", err_count, 1);
        ack = 1'b0; clr = 1'b0;
        clear_errs();

        // Ack on the last allowed cycle restarts the timer
        stb = 1'b1; cyc = 1'b1;
        tick(); tick(); tick();
        ack = 1'b1; tick(); ack = 1'b0;
        tick(); tick();
        stb = 1'b0; cyc = 1'b0; tick();
        check_eq("ack_in_time", err_flags, 0);
        check_eq("ack_in_time_cnt", err_count, 0);

        // Counter saturation with stb without cyc
        stb = 1'b1;
        tick(); tick(); tick();
        check_eq("sat_3", err_count, 3);
        tick();
        check_eq("sat_hold", err_count, 3);
        check_eq("sat_flags", err_flags, 8'h20);
        stb = 1'b0; tick();

        // Asynchronous reset while waiting for refreshes
        en = 1'b0; nops(1);
        en = 1'b1; nops(1);
        nops(8);
        issue(C_PRE, 2'd0, 1'b1);
        issue(C_AREF, 2'd0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_flags", err_flags, 0);
        check_eq("arst_count", err_count, 0);
        check_eq("arst_pulse", err_pulse, 0);
        check_eq("arst_init", init_done, 0);
        tick();
        rst = 1'b0;
        issue(C_AREF, 2'd0, 1'b0);
        issue(C_MRS, 2'd0, 1'b0);
        nops(1);
        check_eq("arst_no_resume", init_done, 0);
        check_eq("arst_no_err", err_flags, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
